spi_cfg_slave: RTL and testbench

- Responder end of the sensor configuration SPI link.
- Receives 16-bit write frames (4-bit address, 12-bit data, MSB first) from the configuration master and decodes them into a 16 x 12-bit register bank.
- Bank resets to the sensor power-on defaults and is readable in parallel by the rest of the FPGA.
- Used in simulation as the behavioural sensor-side model, and in hardware as a shadow copy of the sensor register map.

---
 rtl/lupa_cfg_pkg.sv | 24 ++
 rtl/spi_cfg_slave_if.sv | 23 ++
 rtl/spi_edge_sync.sv | 25 ++
 rtl/spi_cfg_slave.sv | 84 ++++++++
 tb/tb_spi_cfg_slave.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/lupa_cfg_pkg.sv
// lupa_cfg_pkg: sensor register map, power-on defaults and slave FSM encoding
package lupa_cfg_pkg;
  localparam int FRAME_BITS = 16;
  localparam logic [3:0] SEQUENCER   = 4'd0;
  localparam logic [3:0] START_X     = 4'd1;
  localparam logic [3:0] START_Y     = 4'd2;
  localparam logic [3:0] NB_PIX      = 4'd3;
  localparam logic [3:0] RES1_LENGTH = 4'd4;
  localparam logic [3:0] RES2_TIMER  = 4'd5;
  localparam logic [3:0] RES3_TIMER  = 4'd6;
  localparam logic [3:0] FT_TIMER    = 4'd7;
  localparam logic [3:0] VCAL        = 4'd8;
  localparam logic [3:0] VBLACK      = 4'd9;
  localparam logic [3:0] VOFFSET     = 4'd10;
  localparam logic [3:0] ANA_IN_ADC  = 4'd11;
  localparam logic [3:0] PGA_SETTING = 4'd12;
  localparam logic [3:0] CALIB_ADC_L = 4'd13;
  localparam logic [3:0] CALIB_ADC_M = 4'd14;
  localparam logic [3:0] CALIB_ADC_H = 4'd15;
  localparam logic [0:15][11:0] REG_DEFAULTS = {
    12'h029, 12'h000, 12'h000, 12'h0A0, 12'h002, 12'h000, 12'h000, 12'h1E1,
    12'h04A, 12'h06B, 12'h055, 12'h0F0, 12'hFB0, 12'hADF, 12'h6DB, 12'h0DB};
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/spi_cfg_slave_if.sv
// spi_cfg_slave_if: SPI pins, parallel read port and write/status reporting
interface spi_cfg_slave_if;
  logic        spi_clk;
  logic        spi_en;
  logic        spi_dat;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_err;
  logic [15:0] written_mask;
  logic        all_loaded;
  logic [7:0]  frame_count;
  modport master (
    output spi_clk, spi_en, spi_dat, rd_addr,
    input  rd_data, wr_stb, wr_addr, wr_data, frame_err, written_mask, all_loaded, frame_count
  );
  modport slave (
    input  spi_clk, spi_en, spi_dat, rd_addr,
    output rd_data, wr_stb, wr_addr, wr_data, frame_err, written_mask, all_loaded, frame_count
  );
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with rise/fall pulses on the synchronized level
module spi_edge_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clock_20,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              q_d;
  always_ff @(posedge clock_20 or posedge reset) begin
    if (reset) begin
      sync <= {STAGES{IDLE_LVL}};
      q_d  <= IDLE_LVL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q_d  <= sync[STAGES-1];
    end
  end
  assign rise = sync[STAGES-1] & ~q_d;
  assign fall = ~sync[STAGES-1] & q_d;
endmodule

// File: rtl/spi_cfg_slave.sv
// spi_cfg_slave: decodes 16-bit SPI write frames into a 16 x 12-bit shadow register bank
module spi_cfg_slave
  import lupa_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic            clock_20,
  input logic            reset,
  spi_cfg_slave_if.slave bus
);
  state_t                 state, state_nxt;
  logic                   clk_rise, clk_fall_unused, en_rise, en_fall;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [15:0]            shift;
  logic [4:0]             cnt;
  logic [11:0]            bank [16];
  logic                   commit, err;
  logic                   wr_stb, frame_err;
  logic [3:0]             wr_addr;
  logic [11:0]            wr_data;
  logic [15:0]            written_mask;
  logic [7:0]             frame_count;
  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_clk_sync (
    .clock_20(clock_20), .reset(reset), .d(bus.spi_clk), .rise(clk_rise), .fall(clk_fall_unused)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_en_sync (
    .clock_20(clock_20), .reset(reset), .d(bus.spi_en), .rise(en_rise), .fall(en_fall)
  );
  always_ff @(posedge clock_20 or posedge reset) begin
    if (reset) dat_sync <= '0;
    else dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.spi_dat};
  end
  always_ff @(posedge clock_20 or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    commit    = state == COMMIT;
    err       = state == SHIFT && en_rise && cnt != 5'(FRAME_BITS);
    if (state == IDLE && en_fall) state_nxt = SHIFT;
    else if (state == SHIFT && en_rise) state_nxt = (cnt == 5'(FRAME_BITS)) ? COMMIT : IDLE;
    else if (commit) state_nxt = IDLE;
  end
  // en_rise wins over a coincident clock edge so the closing edge never adds a bit
  always_ff @(posedge clock_20 or posedge reset) begin
    if (reset) begin
      shift        <= '0;
      cnt          <= '0;
      wr_stb       <= 1'b0;
      frame_err    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      written_mask <= '0;
      frame_count  <= '0;
      for (int i = 0; i < 16; i++) bank[i] <= REG_DEFAULTS[i];
    end else begin
      wr_stb    <= commit;
      frame_err <= err;
      if (state == IDLE && en_fall) begin
        shift <= '0;
        cnt   <= '0;
      end else if (state == SHIFT && clk_rise && !en_rise) begin
        shift <= {shift[14:0], dat_sync[SYNC_STAGES-1]};
        cnt   <= (&cnt) ? cnt : cnt + 5'd1;
      end
      if (commit) begin
        bank[shift[15:12]]         <= shift[11:0];
        wr_addr                    <= shift[15:12];
        wr_data                    <= shift[11:0];
        written_mask[shift[15:12]] <= 1'b1;
        frame_count                <= frame_count + 8'd1;
      end
    end
  end
  assign bus.rd_data      = bank[bus.rd_addr];
  assign bus.wr_stb       = wr_stb;
  assign bus.frame_err    = frame_err;
  assign bus.wr_addr      = wr_addr;
  assign bus.wr_data      = wr_data;
  assign bus.written_mask = written_mask;
  assign bus.all_loaded   = &written_mask;
  assign bus.frame_count  = frame_count;
endmodule

// File: tb/tb_spi_cfg_slave.sv
// tb_spi_cfg_slave: directed frames against hand-computed register map expectations
module tb_spi_cfg_slave;
  logic clock_20 = 1'b0;
  logic reset    = 1'b1;
  int   total    = 0;
  int   failed   = 0;
  int   stb_n    = 0;
  int   err_n    = 0;
  int   stb0, err0;
  logic [11:0] defaults [16] = '{12'h029, 12'h000, 12'h000, 12'h0A0, 12'h002, 12'h000, 12'h000, 12'h1E1,
                                 12'h04A, 12'h06B, 12'h055, 12'h0F0, 12'hFB0, 12'hADF, 12'h6DB, 12'h0DB};
  spi_cfg_slave_if bus ();
  spi_cfg_slave #(.SYNC_STAGES(2)) dut (.clock_20(clock_20), .reset(reset), .bus(bus));
  always #5 clock_20 = ~clock_20;
  always @(negedge clock_20) begin
    if (bus.wr_stb === 1'b1) stb_n++;
    if (bus.frame_err === 1'b1) err_n++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clock_20);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [3:0] a);
    bus.rd_addr = a;
    #1;
  endtask
  task automatic send(input logic [31:0] v, input int n, input bit coinc);
    bus.spi_en = 1'b0;
    cyc(4);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_dat = v[i];
      cyc(2);
      bus.spi_clk = 1'b1;
      cyc(2);
      bus.spi_clk = 1'b0;
    end
    cyc(2);
    if (coinc) begin
      bus.spi_dat = 1'b1;
      bus.spi_clk = 1'b1;
    end
    bus.spi_en = 1'b1;
    cyc(2);
    bus.spi_clk = 1'b0;
    cyc(8);
  endtask
  task automatic do_reset();
    bus.spi_clk = 1'b0;
    bus.spi_en  = 1'b1;
    bus.spi_dat = 1'b0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
  endtask
  initial begin
    bus.rd_addr = '0;
    do_reset();
    check("rst_wr_stb", 32'(bus.wr_stb), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    check("rst_mask", 32'(bus.written_mask), 0);
    check("rst_all_loaded", 32'(bus.all_loaded), 0);
    check("rst_frame_count", 32'(bus.frame_count), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check($sformatf("default_%0d", a), 32'(bus.rd_data), 32'(defaults[a]));
    end
    stb0 = stb_n; err0 = err_n;
    send(32'h30A5, 16, 1'b0);
    check("f1_stb", stb_n - stb0, 1);
    check("f1_err", err_n - err0, 0);
    check("f1_wr_addr", 32'(bus.wr_addr), 3);
    check("f1_wr_data", 32'(bus.wr_data), 32'h0A5);
    rd(4'd3);
    check("f1_rd3", 32'(bus.rd_data), 32'h0A5);
    check("f1_count", 32'(bus.frame_count), 1);
    check("f1_mask", 32'(bus.written_mask), 32'h0008);
    stb0 = stb_n; err0 = err_n;
    send(32'h3FF, 10, 1'b0);
    check("short_err", err_n - err0, 1);
    check("short_stb", stb_n - stb0, 0);
    rd(4'd0);
    check("short_rd0", 32'(bus.rd_data), 32'h029);
    rd(4'd3);
    check("short_rd3", 32'(bus.rd_data), 32'h0A5);
    stb0 = stb_n; err0 = err_n;
    send(32'h1_8123, 17, 1'b0);
    check("long_err", err_n - err0, 1);
    check("long_stb", stb_n - stb0, 0);
    check("long_count", 32'(bus.frame_count), 1);
    rd(4'd8);
    check("long_rd8", 32'(bus.rd_data), 32'h04A);
    rd(4'd0);
    check("long_rd0", 32'(bus.rd_data), 32'h029);
    do_reset();
    stb0 = stb_n; err0 = err_n;
    for (int a = 0; a < 16; a++) begin
      check($sformatf("b2b_loaded_%0d", a), 32'(bus.all_loaded), 0);
      send({16'h0, 4'(a), 12'(a * 12'h111)}, 16, 1'b0);
    end
    check("b2b_stb", stb_n - stb0, 16);
    check("b2b_err", err_n - err0, 0);
    check("b2b_mask", 32'(bus.written_mask), 32'hFFFF);
    check("b2b_all_loaded", 32'(bus.all_loaded), 1);
    check("b2b_count", 32'(bus.frame_count), 16);
    check("b2b_wr_addr", 32'(bus.wr_addr), 15);
    check("b2b_wr_data", 32'(bus.wr_data), 32'hFFF);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check($sformatf("b2b_rd_%0d", a), 32'(bus.rd_data), 32'(a * 12'h111));
    end
    stb0 = stb_n; err0 = err_n;
    send(32'h63C5, 16, 1'b1);
    check("coinc_stb", stb_n - stb0, 1);
    check("coinc_err", err_n - err0, 0);
    check("coinc_wr_addr", 32'(bus.wr_addr), 6);
    check("coinc_wr_data", 32'(bus.wr_data), 32'h3C5);
    rd(4'd6);
    check("coinc_rd6", 32'(bus.rd_data), 32'h3C5);
    check("coinc_count", 32'(bus.frame_count), 17);
    stb0 = stb_n; err0 = err_n;
    bus.spi_en = 1'b0;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      bus.spi_dat = i[0];
      cyc(2);
      bus.spi_clk = 1'b1;
      cyc(2);
      bus.spi_clk = 1'b0;
    end
    do_reset();
    cyc(8);
    check("mid_rst_stb", stb_n - stb0, 0);
    check("mid_rst_err", err_n - err0, 0);
    check("mid_rst_count", 32'(bus.frame_count), 0);
    check("mid_rst_mask", 32'(bus.written_mask), 0);
    rd(4'd3);
    check("mid_rst_rd3", 32'(bus.rd_data), 32'h0A0);
    rd(4'd6);
    check("mid_rst_rd6", 32'(bus.rd_data), 32'h000);
    send(32'h9123, 16, 1'b0);
    check("post_rst_stb", stb_n - stb0, 1);
    check("post_rst_err", err_n - err0, 0);
    check("post_rst_count", 32'(bus.frame_count), 1);
    check("post_rst_mask", 32'(bus.written_mask), 32'h0200);
    rd(4'd9);
    check("post_rst_rd9", 32'(bus.rd_data), 32'h123);
    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end
endmodule
